// File: rtl/sub_bus_master.sv
// sub_bus_master
//   Initiator for the 20-bit address / 64-bit data register sub-bus.
//   Accepts single or burst register commands over a valid/ready handshake,
//   breaks them into one-word bus strobes, and returns read data plus a
//   completion pulse to the requester.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_wr                1 = write burst, 0 = read burst
//   cmd_addr              start word address
//   cmd_len               burst length minus one
//   wr_valid/wr_ready     write data handshake, wr_data is the word
//   rsp_valid/rsp_data    read data return (no back-pressure)
//   cmd_done              one-cycle pulse on command completion
//   sub_cs/sub_wr/sub_rd  registered bus strobes
//   sub_addr/sub_din      registered bus address and write data
//   sub_dout              bus read data, valid RD_LAT cycles after sub_rd
module sub_bus_master #(
  parameter int RD_LAT    = 1,
  parameter int MAX_LEN_W = 4,
  parameter int DATA_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [19:0]          cmd_addr,
  input  logic [MAX_LEN_W-1:0] cmd_len,
  input  logic                 wr_valid,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ready,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 cmd_done,
  output logic                 sub_cs,
  output logic                 sub_wr,
  output logic                 sub_rd,
  output logic [19:0]          sub_addr,
  output logic [DATA_W-1:0]    sub_din,
  input  logic [DATA_W-1:0]    sub_dout
);

  localparam int CNT_W = MAX_LEN_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [11:0]        hi_q, hi_nxt;
  logic [7:0]         off_q, off_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               sub_last;
  logic               wr_nxt, rd_nxt, last_nxt;
  logic [19:0]        addr_nxt;
  logic [DATA_W-1:0]  din_nxt;
  logic               done_nxt, ready_nxt;
  logic               accept, wr_acc;
  logic [RD_LAT-1:0]  rd_vld_p, rd_last_p;

  // Offset within the 256-word slave window; wraps, upper bits untouched.
  function automatic logic [7:0] next_off(input logic [7:0] off);
    return off + 8'd1;
  endfunction

  assign accept   = cmd_valid & cmd_ready;
  assign wr_ready = (state == WRITE) && (cnt_q != '0);
  assign wr_acc   = wr_valid & wr_ready;

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_q;
    off_nxt   = off_q;
    cnt_nxt   = cnt_q;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    last_nxt  = 1'b0;
    addr_nxt  = sub_addr;
    din_nxt   = sub_din;
    // Completion: one cycle after the last write strobe, or together with
    // the last read response leaving the capture pipe.
    done_nxt  = (sub_wr & sub_last) | rd_last_p[RD_LAT-1];

    case (state)
      IDLE: begin
        if (accept) begin
          hi_nxt = cmd_addr[19:8];
          if (cmd_wr) begin
            state_nxt = WRITE;
            off_nxt   = cmd_addr[7:0];
            cnt_nxt   = CNT_W'(cmd_len) + CNT_W'(1);
          end else begin
            // First read strobe goes out on the accept edge itself.
            rd_nxt    = 1'b1;
            addr_nxt  = cmd_addr;
            off_nxt   = next_off(cmd_addr[7:0]);
            cnt_nxt   = CNT_W'(cmd_len);
            last_nxt  = (cmd_len == '0);
            state_nxt = (cmd_len == '0) ? DRAIN : READ;
          end
        end
      end
      WRITE: begin
        if (wr_acc) begin
          wr_nxt   = 1'b1;
          addr_nxt = {hi_q, off_q};
          din_nxt  = wr_data;
          off_nxt  = next_off(off_q);
          cnt_nxt  = cnt_q - CNT_W'(1);
          last_nxt = (cnt_q == CNT_W'(1));
          if (cnt_q == CNT_W'(1))
            state_nxt = DRAIN;
        end
      end
      READ: begin
        rd_nxt   = 1'b1;
        addr_nxt = {hi_q, off_q};
        off_nxt  = next_off(off_q);
        cnt_nxt  = cnt_q - CNT_W'(1);
        last_nxt = (cnt_q == CNT_W'(1));
        if (cnt_q == CNT_W'(1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (done_nxt)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Ready stays low in the cmd_done cycle so the two never overlap.
    ready_nxt = (state_nxt == IDLE) && !done_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      cmd_ready <= 1'b0;
      cmd_done  <= 1'b0;
      sub_cs    <= 1'b0;
      sub_wr    <= 1'b0;
      sub_rd    <= 1'b0;
      sub_last  <= 1'b0;
      sub_addr  <= '0;
      sub_din   <= '0;
      rd_vld_p  <= '0;
      rd_last_p <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      // Stage: command sequencing -> registered bus strobe
      state     <= state_nxt;
      hi_q      <= hi_nxt;
      off_q     <= off_nxt;
      cnt_q     <= cnt_nxt;
      cmd_ready <= ready_nxt;
      cmd_done  <= done_nxt;
      sub_cs    <= wr_nxt | rd_nxt;
      sub_wr    <= wr_nxt;
      sub_rd    <= rd_nxt;
      sub_last  <= last_nxt;
      sub_addr  <= addr_nxt;
      sub_din   <= din_nxt;

      // Stage: read strobe -> RD_LAT-deep tracking pipe
      rd_vld_p[0]  <= sub_rd;
      rd_last_p[0] <= sub_rd & sub_last;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_p[i]  <= rd_vld_p[i-1];
        rd_last_p[i] <= rd_last_p[i-1];
      end

      // Stage: pipe tail -> captured response
      rsp_valid <= rd_vld_p[RD_LAT-1];
      if (rd_vld_p[RD_LAT-1])
        rsp_data <= sub_dout;
    end
  end

endmodule

// File: tb/tb_sub_bus_master.sv
module tb_sub_bus_master;

  localparam int RD_LAT = 1;
  localparam int LW     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [19:0]   cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [63:0]   wr_data = '0;
  logic          wr_ready;
  logic          rsp_valid;
  logic [63:0]   rsp_data;
  logic          cmd_done;
  logic          sub_cs, sub_wr, sub_rd;
  logic [19:0]   sub_addr;
  logic [63:0]   sub_din;
  logic [63:0]   sub_dout;

  always #5 clk = ~clk;

  sub_bus_master #(.RD_LAT(RD_LAT), .MAX_LEN_W(LW), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cmd_done(cmd_done),
    .sub_cs(sub_cs), .sub_wr(sub_wr), .sub_rd(sub_rd),
    .sub_addr(sub_addr), .sub_din(sub_din), .sub_dout(sub_dout)
  );

  typedef struct { int cyc; logic wr; logic rd; logic [19:0] addr; logic [63:0] din; } strobe_t;
  typedef struct { int cyc; logic [63:0] data; } rsp_t;

  strobe_t strobes[$];
  rsp_t    rsps[$];
  int      dones[$];
  int      cyc = 0;
  int      viol = 0;
  int      n_checks = 0, n_pass = 0, n_fail = 0;
  int      acc = 0;
  logic [63:0] wdata [16];
  int          cons  [16];
  logic [63:0] ref_mem   [logic [19:0]];
  logic [63:0] slave_mem [logic [19:0]];
  logic [63:0] dq [RD_LAT];

  assign sub_dout = dq[RD_LAT-1];

  function automatic logic [63:0] dflt(input logic [19:0] a);
    return {32'hDEAD_BEEF, 12'h000, a};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus slave: stores writes, returns read data RD_LAT cycles after sub_rd.
  initial begin
    logic [63:0] nxt;
    for (int i = 0; i < RD_LAT; i++) dq[i] = '0;
    forever begin
      @(negedge clk);
      if (sub_cs && sub_wr) slave_mem[sub_addr] = sub_din;
      if (sub_cs && sub_rd)
        nxt = slave_mem.exists(sub_addr) ? slave_mem[sub_addr] : dflt(sub_addr);
      else
        nxt = {$urandom, $urandom};
      @(posedge clk);
      #1;
      for (int i = RD_LAT-1; i > 0; i--) dq[i] = dq[i-1];
      dq[0] = nxt;
    end
  end

  // Monitor: records bus strobes, responses and completions with cycle stamps.
  initial forever begin
    strobe_t s;
    rsp_t    r;
    @(negedge clk);
    if (rst_n) begin
      if (sub_cs) begin
        s.cyc = cyc; s.wr = sub_wr; s.rd = sub_rd; s.addr = sub_addr; s.din = sub_din;
        strobes.push_back(s);
      end
      if ((sub_cs !== (sub_wr | sub_rd)) || (sub_wr & sub_rd) ||
          (cmd_done & cmd_ready) || (wr_ready & cmd_ready))
        viol++;
      if (rsp_valid) begin
        r.cyc = cyc; r.data = rsp_data;
        rsps.push_back(r);
      end
      if (cmd_done) dones.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    strobes.delete();
    rsps.delete();
    dones.delete();
  endtask

  task automatic send_cmd(input logic wr, input logic [19:0] a, input int len, input bit hold);
    bit got = 0;
    cmd_wr = wr; cmd_addr = a; cmd_len = LW'(len); cmd_valid = 1'b1;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; acc = cyc; end
      @(posedge clk); #1;
    end
    if (!hold) cmd_valid = 1'b0;
    check("cmd_accepted", 64'(got), 64'd1);
  endtask

  // mode 0: data always present; 1: absent on 2nd and 4th offered cycles; 2: random gaps
  task automatic feed_write(input int len, input int mode);
    int idx = 0, offered = 0, guard = 0;
    while (idx <= len && guard < 200) begin
      case (mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = !(offered == 1 || offered == 3);
        default: wr_valid = ($urandom_range(0, 2) != 0);
      endcase
      wr_data = wr_valid ? wdata[idx] : {$urandom, $urandom};
      @(negedge clk);
      if (wr_ready) offered++;
      if (wr_valid && wr_ready) begin cons[idx] = cyc; idx++; end
      guard++;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check("wr_words_taken", 64'(idx), 64'(len + 1));
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    while (dones.size() < n && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (4) begin @(posedge clk); #1; end
    check("done_seen", 64'(dones.size() >= n), 64'd1);
  endtask

  // Expected behaviour derived from the burst rules: wrapped addresses,
  // strobe timing, in-order responses and completion timing.
  task automatic check_cmd(input logic wr, input logic [19:0] a, input int len, input int acc_cyc);
    int          n = len + 1;
    int          scyc [16];
    logic [19:0] ea   [16];
    int          last_cyc = -1;
    int          d;
    strobe_t     s;
    rsp_t        r;
    for (int i = 0; i < n; i++) ea[i] = {a[19:8], a[7:0] + 8'(i)};
    check("strobe_count", 64'(strobes.size() >= n), 64'd1);
    if (strobes.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        s = strobes.pop_front();
        scyc[i] = s.cyc;
        last_cyc = s.cyc;
        check($sformatf("addr[%0d]", i), 64'(s.addr), 64'(ea[i]));
        check($sformatf("dir[%0d]", i), 64'({s.wr, s.rd}), wr ? 64'd2 : 64'd1);
        if (wr) begin
          check($sformatf("din[%0d]", i), s.din, wdata[i]);
          check($sformatf("wr_cyc[%0d]", i), 64'(s.cyc), 64'(cons[i] + 1));
          ref_mem[ea[i]] = wdata[i];
        end else begin
          check($sformatf("rd_cyc[%0d]", i), 64'(s.cyc), 64'(acc_cyc + 1 + i));
        end
      end
    end
    if (!wr) begin
      check("rsp_count", 64'(rsps.size() >= n), 64'd1);
      if (rsps.size() >= n) begin
        for (int i = 0; i < n; i++) begin
          r = rsps.pop_front();
          last_cyc = r.cyc;
          check($sformatf("rsp_data[%0d]", i), r.data, ref_rd(ea[i]));
          check($sformatf("rsp_cyc[%0d]", i), 64'(r.cyc), 64'(scyc[i] + RD_LAT + 1));
        end
      end
    end
    if (dones.size() > 0) begin
      d = dones.pop_front();
      check("done_cyc", 64'(d), wr ? 64'(last_cyc + 1) : 64'(last_cyc));
    end
  endtask

  task automatic run_cmd(input logic wr, input logic [19:0] a, input int len, input int mode, input bit keep);
    clear_q();
    if (wr && !keep)
      for (int i = 0; i <= len; i++) wdata[i] = {$urandom, $urandom};
    send_cmd(wr, a, len, 1'b0);
    if (wr) feed_write(len, mode);
    wait_done(1);
    check_cmd(wr, a, len, acc);
    check("stray_beats", 64'(strobes.size() + rsps.size() + dones.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, b2b_exp;
    int g;
    logic        rw;
    logic [19:0] ra;
    int          rl;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_ctl", 64'({sub_cs, sub_wr, sub_rd, rsp_valid, cmd_done, cmd_ready, wr_ready}), 64'd0);
    check("rst_bus", 64'(sub_addr) | sub_din | rsp_data, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // Single write
    wdata[0] = 64'hA5A5_0000_0000_0001;
    run_cmd(1'b1, 20'h00123, 0, 0, 1'b1);

    // Single read
    run_cmd(1'b0, 20'h00204, 0, 0, 1'b0);

    // 16-word read wrapping in the slave window
    run_cmd(1'b0, 20'h001FE, 15, 0, 1'b0);

    // 4-word write with data gaps, then read it back
    run_cmd(1'b1, 20'h00310, 3, 1, 1'b0);
    run_cmd(1'b0, 20'h00310, 3, 0, 1'b0);

    // Reset during beat 5 of an 8-word read
    clear_q();
    send_cmd(1'b0, 20'h00450, 7, 1'b0);
    g = 0;
    while (strobes.size() < 5 && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    check("abort_beat5", 64'(strobes.size()), 64'd5);
    rst_n = 1'b0;
    #1;
    check("abort_ctl", 64'({sub_cs, sub_wr, sub_rd, rsp_valid, cmd_done, cmd_ready, wr_ready}), 64'd0);
    check("abort_bus", 64'(sub_addr) | sub_din | rsp_data, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_q();
    repeat (10) begin @(posedge clk); #1; end
    check("abort_quiet", 64'(strobes.size() + rsps.size() + dones.size()), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    run_cmd(1'b0, 20'h00204, 0, 0, 1'b0);

    // Back-to-back read then write with cmd_valid held
    clear_q();
    wdata[0] = {$urandom, $urandom};
    send_cmd(1'b0, 20'h00520, 1, 1'b1);
    acc1 = acc;
    send_cmd(1'b1, 20'h00600, 0, 1'b0);
    acc2 = acc;
    feed_write(0, 0);
    wait_done(2);
    b2b_exp = (dones.size() > 0) ? dones[0] + 1 : -1;
    check("b2b_accept_cyc", 64'(acc2), 64'(b2b_exp));
    check_cmd(1'b0, 20'h00520, 1, acc1);
    check_cmd(1'b1, 20'h00600, 0, acc2);
    check("b2b_stray", 64'(strobes.size() + rsps.size() + dones.size()), 64'd0);

    // Randomized commands
    for (int t = 0; t < 14; t++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 20'($urandom);
      rl = $urandom_range(0, 15);
      run_cmd(rw, ra, rl, rw ? $urandom_range(0, 2) : 0, 1'b0);
      if (rw) run_cmd(1'b0, ra, rl, 0, 1'b0);
    end

    check("bus_invariants", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sub_bus_master.md
Name: sub_bus_master

Overview:
- Initiator for the 20-bit, 64-bit-data register sub-bus.
- Drives sub_cs / sub_wr / sub_rd / sub_addr / sub_din on the bus side.
- Captures read data returned on sub_dout after a fixed latency.
- Upstream, the SRIO request handler issues single or burst register commands through a valid/ready handshake. This block serialises them into one-word bus strobes and returns read data and completion to the handler.

Parameters:
- RD_LAT, 1, cycles from a sub_rd strobe cycle to the cycle in which sub_dout is valid. Legal range 1..4.
- MAX_LEN_W, 4, width of cmd_len. A burst is cmd_len+1 words, so the default allows 1..16 words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  20  start word address
- cmd_len  in  MAX_LEN_W  burst length minus one
- wr_valid  in  1  write data word available
- wr_data  in  64  write data word
- wr_ready  out  1  write data word consumed this cycle
- rsp_valid  out  1  read data word valid (no back-pressure)
- rsp_data  out  64  read data word
- cmd_done  out  1  one-cycle pulse when the current command completes
- sub_cs  out  1  bus select, high only in strobe cycles
- sub_wr  out  1  bus write strobe
- sub_rd  out  1  bus read strobe
- sub_addr  out  20  bus word address
- sub_din  out  64  bus write data
- sub_dout  in  64  bus read data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, except cmd_ready = 1 once out of reset (IDLE). Reset mid-command aborts the command: no cmd_done, in-flight read data discarded, FSM returns to IDLE.
- Bus outputs are registered. sub_cs is high exactly when sub_wr or sub_rd is high. sub_wr and sub_rd are never high together.
- State machine: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_addr, cmd_len and cmd_wr.
  - Go to WRITE or READ; cmd_ready drops in the next cycle.
- Address sequencing:
  - Beat n uses sub_addr = {cmd_addr[19:8], cmd_addr[7:0]+n mod 256}.
  - Bursts wrap inside the 256-word slave window. The upper 12 bits never change during a command.
- WRITE:
  - wr_ready = 1 while beats remain.
  - Each cycle with wr_valid & wr_ready registers one strobe for the next cycle: sub_cs = 1, sub_wr = 1, sub_din = wr_data, current beat address.
  - A cycle without wr_valid gives no strobe (sub_cs = 0); the address does not advance.
  - After the last beat is accepted, wr_ready = 0.
  - cmd_done pulses in the cycle after the last sub_wr strobe cycle, then the FSM returns to IDLE.
- READ:
  - Issues sub_rd strobes on consecutive cycles, one per beat, with no gaps.
  - Command accepted at the edge ending cycle T gives strobes in cycles T+1 .. T+N.
  - After the last strobe, go to DRAIN.
- Read capture:
  - A valid shift pipe of depth RD_LAT tracks each strobe.
  - sub_dout is sampled at the edge ending cycle k+RD_LAT for a strobe in cycle k.
  - rsp_valid = 1 and rsp_data = the sampled word in cycle k+RD_LAT+1.
  - Responses come back in issue order, one per cycle for consecutive strobes.
- DRAIN:
  - Wait until the last response is delivered.
  - cmd_done is asserted in the same cycle as the final rsp_valid, then the FSM returns to IDLE.
- cmd_done and cmd_ready are never high in the same cycle. The next command is accepted at the earliest in the cycle after cmd_done.
- wr_valid in any state other than WRITE is ignored (wr_ready = 0).

Test Plan:
- Single write, addr 0x00123, len 0, wr_data 0xA5A5_0000_0000_0001 present -> one cycle with sub_cs=1, sub_wr=1, sub_addr=0x00123, sub_din=0xA5A5_0000_0000_0001; cmd_done pulses in the next cycle.
- Single read, addr 0x00204, RD_LAT=1, bus model returns 0xDEAD_BEEF_0000_0204 for that address -> sub_rd strobe in cycle T+1; rsp_valid with that data in cycle T+3; cmd_done in the same cycle.
- 16-word read burst from 0x001FE -> addresses 0x001FE, 0x001FF, 0x00100 .. 0x0010D on 16 consecutive strobes; 16 consecutive rsp_valid beats in order; cmd_done on the last beat.
- 4-word write from 0x00310 with wr_valid low on the 2nd and 4th offered cycles -> exactly 4 sub_wr strobes, addresses 0x00310..0x00313, sub_cs=0 in the gap cycles, data in order.
- Reset pulse during beat 5 of an 8-word read -> all outputs 0 asynchronously; no rsp_valid or cmd_done afterwards; cmd_ready=1 after release; a new single read then completes normally.
- Back-to-back commands (read len 1, then write len 0) with cmd_valid held high -> second command accepted in the cycle after the first cmd_done; no overlap of sub_rd and sub_wr.
